// File: rtl/andtree_seq_pkg.sv
// andtree_seq_pkg: shared state encoding, default parameters and FIFO entry layout for the AND-tree stimulus sequencer
package andtree_seq_pkg;
    localparam int DEF_N_IN        = 4;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_SETTLE_MAX  = 16;
    localparam int DEF_HOLD        = 2;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic [DEF_N_IN-1:0] data;
        logic                exp_z;
    } vec_entry_t;
endpackage

// File: rtl/and_tree_seq_fifo.sv
// and_tree_seq_fifo: synchronous vector FIFO with valid/ready push and pop strobe; a push is refused while full even if a pop happens in that cycle
module and_tree_seq_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full       = count == (AW+1)'(DEPTH);
    assign empty      = count == '0;
    assign push_ready = !full;
    assign do_push    = push_valid && !full;
    assign do_pop     = pop && !empty;
    assign head       = mem[rd_ptr];

    // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/and_tree_stim_sequencer.sv
// and_tree_stim_sequencer: buffers vectors, drives AND-tree leaves, waits for the synchronized root to settle and reports per-vector failures (optional stats: ANDTREE_SEQ_STATS_EN)
module and_tree_stim_sequencer
    import andtree_seq_pkg::*;
#(
    parameter int N_IN        = DEF_N_IN,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SETTLE_MAX  = DEF_SETTLE_MAX,
    parameter int HOLD        = DEF_HOLD,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vec_valid,
    output logic                       vec_ready,
    input  logic [N_IN-1:0]            vec_data,
    input  logic                       vec_expect,
    input  logic                       start,
    output logic [N_IN-1:0]            tree_in,
    input  logic                       tree_out,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       err_valid,
    output logic [$clog2(DEPTH):0]     err_index,
`ifdef ANDTREE_SEQ_STATS_EN
    output logic [15:0]                stat_vectors,
    output logic [15:0]                stat_fails,
    output logic [$clog2(SETTLE_MAX+1)-1:0] stat_max_settle,
`endif
    output logic                       err_timeout
);
    localparam int IW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(SETTLE_MAX + 1);
    localparam int MW = $clog2(HOLD + 1);

    typedef struct packed {
        logic [N_IN-1:0] data;
        logic            exp_z;
    } entry_t;

    entry_t                 head;
    logic                   empty, full_unused, pop;
    state_e                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_z, exp_q, ok_q;
    logic [TW-1:0]          timer, t_next;
    logic [MW-1:0]          mcnt, m_next;
    logic [IW-1:0]          ordinal;
    logic                   settled, timeout, run_start;

    and_tree_seq_fifo #(.W(N_IN + 1), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_valid(vec_valid),
        .push_ready(vec_ready),
        .push_data ({vec_data, vec_expect}),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full_unused)
    );

    assign sync_z      = sync[SYNC_STAGES-1];
    assign pop         = state == S_APPLY;
    assign run_start   = state == S_IDLE && start && !empty;
    assign t_next      = timer + 1'b1;
    assign m_next      = (sync_z == exp_q) ? mcnt + 1'b1 : '0;
    assign settled     = m_next == MW'(HOLD);
    assign timeout     = t_next == TW'(SETTLE_MAX);
    assign busy        = state != S_IDLE;
    assign done        = state == S_DONE;
    assign err_valid   = state == S_CHECK && !ok_q;
    assign err_timeout = err_valid;
    assign err_index   = ordinal;

    // multi-flop synchronizer for the asynchronous tree root
    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else sync <= {sync[SYNC_STAGES-2:0], tree_out};
    end

    // run sequencing: apply a vector, wait for a stable match or timeout, then record the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tree_in <= '0;
            pass    <= 1'b1;
            ordinal <= '0;
            timer   <= '0;
            mcnt    <= '0;
            exp_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run_start) begin
                        state   <= S_APPLY;
                        pass    <= 1'b1;
                        ordinal <= '0;
                    end
                end
                S_APPLY: begin
                    tree_in <= head.data;
                    exp_q   <= head.exp_z;
                    timer   <= '0;
                    mcnt    <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= t_next;
                    mcnt  <= m_next;
                    if (settled || timeout) begin
                        state <= S_CHECK;
                        ok_q  <= settled;
                    end
                end
                S_CHECK: begin
                    if (!ok_q) pass <= 1'b0;
                    ordinal <= ordinal + 1'b1;
                    state   <= empty ? S_DONE : S_APPLY;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ANDTREE_SEQ_STATS_EN
    // saturating run statistics, restarted with every run
    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            stat_vectors    <= '0;
            stat_fails      <= '0;
            stat_max_settle <= '0;
        end else begin
            if (state == S_CHECK && !(&stat_vectors)) stat_vectors <= stat_vectors + 1'b1;
            if (err_valid && !(&stat_fails)) stat_fails <= stat_fails + 1'b1;
            if (state == S_WAIT && settled && t_next > stat_max_settle) stat_max_settle <= t_next;
        end
    end
`endif
endmodule

// File: tb/tb_and_tree_stim_sequencer.sv
// tb_and_tree_stim_sequencer: table-driven bench with a 3-cycle AND-tree model and an expected-error scoreboard
module tb_and_tree_stim_sequencer;
    typedef struct {
        logic [3:0] data;
        logic       exp_z;
        logic       fail;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, vec_valid, vec_ready, vec_expect, start, tree_out;
    logic [3:0] vec_data, tree_in;
    logic       busy, done, pass, err_valid, err_timeout;
    logic [3:0] err_index;
    logic [2:0] td = '0;
    logic       ovr_en = 1'b0, ovr_val = 1'b0;

    int checks = 0, errors = 0, done_cnt = 0, run_pos = 0;
    int err_q[$];

    and_tree_stim_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_data   (vec_data),
        .vec_expect (vec_expect),
        .start      (start),
        .tree_in    (tree_in),
        .tree_out   (tree_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_valid  (err_valid),
        .err_index  (err_index),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // AND tree settles three cycles after its leaves change
    always @(posedge clk) td <= {td[1:0], &tree_in};
    assign tree_out = ovr_en ? ovr_val : td[2];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (done) done_cnt++;
        if (err_valid) begin
            if (err_q.size() == 0) check("unexpected_err_index", int'(err_index), -1);
            else begin
                check("err_index", int'(err_index), err_q.pop_front());
                check("err_timeout", int'(err_timeout), 1);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input vec_t v);
        int n = 0;
        vec_valid  = 1'b1;
        vec_data   = v.data;
        vec_expect = v.exp_z;
        while (!vec_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_accepted", int'(vec_ready), 1);
        if (v.fail) err_q.push_back(run_pos);
        run_pos++;
        tick();
        vec_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        check("done_seen", int'(done), 1);
        tick();
        check("err_q_drained", err_q.size(), 0);
        err_q.delete();
    endtask

    initial begin
        vec_t t1[2];
        vec_t t2[5];
        vec_t t6[4];
        int   d0, n;
        t1 = '{'{4'b0000, 1'b0, 1'b0}, '{4'b1111, 1'b1, 1'b0}};
        t2 = '{'{4'b1111, 1'b1, 1'b0}, '{4'b1110, 1'b0, 1'b0}, '{4'b0110, 1'b0, 1'b0},
               '{4'b0111, 1'b0, 1'b0}, '{4'b1111, 1'b1, 1'b0}};
        t6 = '{'{4'b0001, 1'b0, 1'b0}, '{4'b0011, 1'b0, 1'b0}, '{4'b0111, 1'b0, 1'b0},
               '{4'b1111, 1'b1, 1'b0}};
        rst = 1'b1; vec_valid = 1'b0; vec_data = '0; vec_expect = 1'b0; start = 1'b0;
        ticks(3);
        rst = 1'b0;
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 1);
        check("rst_err_valid", int'(err_valid), 0);
        check("rst_err_index", int'(err_index), 0);
        check("rst_err_timeout", int'(err_timeout), 0);
        check("rst_tree_in", int'(tree_in), 0);
        check("rst_vec_ready", int'(vec_ready), 1);

        // two-vector run
        run_pos = 0; d0 = done_cnt;
        for (int i = 0; i < 2; i++) push(t1[i]);
        go();
        check("t1_busy", int'(busy), 1);
        wait_done(100);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_pass", int'(pass), 1);
        check("t1_tree_in", int'(tree_in), 15);

        // single-leaf transitions
        run_pos = 0; d0 = done_cnt;
        for (int i = 0; i < 5; i++) push(t2[i]);
        go();
        wait_done(200);
        check("t2_done_once", done_cnt - d0, 1);
        check("t2_pass", int'(pass), 1);

        // wrong expectation times out after SETTLE_MAX wait cycles
        run_pos = 0;
        push('{4'b1111, 1'b0, 1'b1});
        go();
        n = 0;
        while (!err_valid && n < 40) begin
            tick();
            n++;
        end
        check("t3_timeout_latency", n, 17);
        wait_done(10);
        check("t3_pass", int'(pass), 0);

        // full FIFO back-pressure across the first pop
        run_pos = 0;
        for (int i = 0; i < 8; i++) push('{4'b1111, 1'b0, 1'b1});
        check("t4_full_ready", int'(vec_ready), 0);
        vec_valid = 1'b1; vec_data = 4'b1111; vec_expect = 1'b0;
        go();
        check("t4_apply_ready", int'(vec_ready), 0);
        tick();
        check("t4_after_pop_ready", int'(vec_ready), 1);
        err_q.push_back(8);
        tick();
        vec_valid = 1'b0;
        check("t4_refilled_ready", int'(vec_ready), 0);
        wait_done(400);
        check("t4_pass", int'(pass), 0);

        // glitching root never holds long enough
        ovr_en = 1'b1; ovr_val = 1'b0;
        ticks(4);
        run_pos = 0;
        push('{4'b1111, 1'b1, 1'b1});
        go();
        n = 0;
        while (!done && n < 60) begin
            ovr_val = ~ovr_val;
            tick();
            n++;
        end
        wait_done(5);
        check("t5_glitch_pass", int'(pass), 0);

        // root high for exactly two sampled cycles is enough
        ovr_val = 1'b0;
        ticks(4);
        run_pos = 0;
        push('{4'b1111, 1'b1, 1'b0});
        go();
        ticks(3);
        ovr_val = 1'b1;
        ticks(2);
        ovr_val = 1'b0;
        wait_done(40);
        check("t5_hold_pass", int'(pass), 1);
        ovr_en = 1'b0;

        // reset in the middle of a run
        ticks(4);
        run_pos = 0;
        for (int i = 0; i < 4; i++) push(t6[i]);
        d0 = done_cnt;
        go();
        n = 0;
        while (tree_in != 4'b0011 && n < 100) begin
            tick();
            n++;
        end
        check("t6_reach_vec2", int'(tree_in), 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        err_q.delete();
        check("t6_busy", int'(busy), 0);
        check("t6_tree_in", int'(tree_in), 0);
        check("t6_vec_ready", int'(vec_ready), 1);
        check("t6_done", int'(done), 0);
        check("t6_pass", int'(pass), 1);
        check("t6_err_index", int'(err_index), 0);
        ticks(3);
        check("t6_no_done", done_cnt - d0, 0);
        go();
        ticks(3);
        check("t6_empty_start_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
